// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder and the stream accumulator built on it.
package cla_pkg;

    localparam int unsigned BASEADDERSIZE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    function automatic int unsigned cntw(input int unsigned maxterms);
        return $clog2(maxterms + 1);
    endfunction

endpackage

// File: rtl/nBitCarryLookAheadAdder.sv
// Combinational NUMBITS-wide adder: 4-bit lookahead slices with group carries chained
// slice to slice.
module nBitCarryLookAheadAdder
    import cla_pkg::*;
#(
    parameter int unsigned NUMBITS = 8
) (
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic               c_in,
    output logic [NUMBITS-1:0] s_out,
    output logic               c_out
);

    localparam int unsigned NSLICES = NUMBITS / BASEADDERSIZE;

    logic [NSLICES:0] carry;

    assign carry[0] = c_in;

    for (genvar k = 0; k < NSLICES; k++) begin : g_slice
        logic [BASEADDERSIZE-1:0] g;
        logic [BASEADDERSIZE-1:0] p;
        logic [BASEADDERSIZE-1:0] c;

        assign g = a_in[k*BASEADDERSIZE +: BASEADDERSIZE] & b_in[k*BASEADDERSIZE +: BASEADDERSIZE];
        assign p = a_in[k*BASEADDERSIZE +: BASEADDERSIZE] ^ b_in[k*BASEADDERSIZE +: BASEADDERSIZE];

        // Every internal carry is a flat sum of products of the slice carry-in.
        assign c[0] = carry[k];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);

        assign carry[k+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                          | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c[0]);

        assign s_out[k*BASEADDERSIZE +: BASEADDERSIZE] = p ^ c;
    end

    assign c_out = carry[NSLICES];

endmodule

// File: rtl/cla_stream_accumulator.sv
// Sums valid/ready operand groups through one carry-lookahead adder and presents the
// group total, beat count and sticky carry flag on a valid/ready result port.
module cla_stream_accumulator
    import cla_pkg::*;
#(
    parameter  int unsigned NUMBITS  = 8,
    parameter  int unsigned MAXTERMS = 16,
    localparam int unsigned CNTW     = cntw(MAXTERMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] out_sum,
    output logic [CNTW-1:0]    out_count,
    output logic               out_ovf
);

    if ((NUMBITS % BASEADDERSIZE) != 0 || MAXTERMS < 1) begin : g_param_check
        $error("cla_stream_accumulator: NUMBITS must be a multiple of 4 and MAXTERMS >= 1");
    end

    acc_state_t         state_q, state_d;
    logic [NUMBITS-1:0] acc_q, acc_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    // Keeps in_ready low for the first cycle rst_n is high again.
    logic               run_q;

    logic [NUMBITS-1:0] sum;
    logic               carry_out;
    logic [CNTW-1:0]    count_inc;
    logic               at_max;
    logic               accept;

    nBitCarryLookAheadAdder #(
        .NUMBITS(NUMBITS)
    ) u_adder (
        .a_in  (acc_q),
        .b_in  (in_data),
        .c_in  (1'b0),
        .s_out (sum),
        .c_out (carry_out)
    );

    assign count_inc = count_q + CNTW'(1);
    assign at_max    = (count_inc == CNTW'(MAXTERMS));
    assign in_ready  = run_q && (state_q != DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = sum;
                    ovf_d   = ovf_q | carry_out;
                    count_d = count_inc;
                    state_d = (in_last || at_max) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            run_q   <= 1'b1;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_stream_accumulator.sv
// Self-checking bench for cla_stream_accumulator (NUMBITS=8, MAXTERMS=4) with a
// plain-arithmetic group-sum reference model.
module tb_cla_stream_accumulator;

    localparam int unsigned NUMBITS  = 8;
    localparam int unsigned MAXTERMS = 4;
    localparam int unsigned CNTW     = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] out_sum;
    logic [CNTW-1:0]    out_count;
    logic               out_ovf;

    int checks = 0;
    int errors = 0;

    cla_stream_accumulator #(
        .NUMBITS  (NUMBITS),
        .MAXTERMS (MAXTERMS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until it is taken (bounded wait).
    task automatic send_beat(input logic [7:0] d, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_beat_timeout: in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_count !== 3'd0 || out_ovf !== 1'b0
                || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: valid=%b sum=%h cnt=%0d ovf=%b rdy=%b required 0/00/0/0/0",
                         out_valid, out_sum, out_count, out_ovf, in_ready);
            end
        end
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 0", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 3'd0 || out_sum !== 8'h00) begin
            errors++;
            $display("FAIL reset_after: rdy=%b valid=%b cnt=%0d sum=%h required 1/0/0/00",
                     in_ready, out_valid, out_count, out_sum);
        end
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 3'd0 || out_sum !== 8'h00 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL pop_clear: valid=%b cnt=%0d sum=%h ovf=%b required 0/0/00/0",
                     out_valid, out_count, out_sum, out_ovf);
        end
    endtask

    task automatic test_basic();
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        send_beat(8'h05, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h35 || out_count !== 3'd3 || out_ovf !== 1'b0
            || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_group: valid=%b sum=%h cnt=%0d ovf=%b rdy=%b required 1/35/3/0/0",
                     out_valid, out_sum, out_count, out_ovf, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'h35) begin
                errors++;
                $display("FAIL basic_backpressure: rdy=%b valid=%b sum=%h required 0/1/35",
                         in_ready, out_valid, out_sum);
            end
        end
        in_valid = 1'b0;
        pop_result();
    endtask

    task automatic test_overflow();
        send_beat(8'hF0, 1'b0);
        send_beat(8'h20, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h10 || out_count !== 3'd2 || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_group: valid=%b sum=%h cnt=%0d ovf=%b required 1/10/2/1",
                     out_valid, out_sum, out_count, out_ovf);
        end
        pop_result();
        send_beat(8'h01, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h01 || out_count !== 3'd1 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_cleared: valid=%b sum=%h cnt=%0d ovf=%b required 1/01/1/0",
                     out_valid, out_sum, out_count, out_ovf);
        end
        pop_result();
        send_beat(8'h80, 1'b0);
        send_beat(8'h80, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h00 || out_count !== 3'd2 || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_to_zero: valid=%b sum=%h cnt=%0d ovf=%b required 1/00/2/1",
                     out_valid, out_sum, out_count, out_ovf);
        end
        pop_result();
    endtask

    task automatic test_maxterms();
        for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h04 || out_count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL maxterms_close: valid=%b sum=%h cnt=%0d rdy=%b required 1/04/4/0",
                     out_valid, out_sum, out_count, in_ready);
        end
        repeat (2) step();
        checks++;
        if (in_ready !== 1'b0 || out_count !== 3'd4 || out_sum !== 8'h04) begin
            errors++;
            $display("FAIL maxterms_held: rdy=%b cnt=%0d sum=%h required 0/4/04",
                     in_ready, out_count, out_sum);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 3'd0) begin
            errors++;
            $display("FAIL maxterms_release: rdy=%b valid=%b cnt=%0d required 1/0/0",
                     in_ready, out_valid, out_count);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 3'd1 || out_sum !== 8'h01) begin
            errors++;
            $display("FAIL maxterms_fifth: valid=%b cnt=%0d sum=%h required 0/1/01",
                     out_valid, out_count, out_sum);
        end
        send_beat(8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd2 || out_sum !== 8'h01) begin
            errors++;
            $display("FAIL maxterms_next: valid=%b cnt=%0d sum=%h required 1/2/01",
                     out_valid, out_count, out_sum);
        end
        pop_result();
    endtask

    task automatic test_random();
        for (int g = 0; g < 1000; g++) begin
            int          len;
            int          exp_acc;
            logic        exp_ovf;
            int          hold;
            logic [7:0]  d;
            logic        last;
            len     = $urandom_range(1, 4);
            exp_acc = 0;
            exp_ovf = 1'b0;
            for (int i = 0; i < len; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int k = 0; k < gap; k++) begin
                    out_ready = 1'($urandom);
                    step();
                end
                checks++;
                if (out_valid !== 1'b0 || out_count !== 3'(i) || out_sum !== 8'(exp_acc)) begin
                    errors++;
                    $display("FAIL random_gap g=%0d: valid=%b cnt=%0d sum=%h required 0/%0d/%h",
                             g, out_valid, out_count, out_sum, i, 8'(exp_acc));
                end
                d    = 8'($urandom_range(0, 255));
                last = (i == len - 1) ? ((len == 4) ? 1'($urandom) : 1'b1) : 1'b0;
                send_beat(d, last);
                exp_acc = exp_acc + int'(d);
                if (exp_acc >= 256) begin
                    exp_ovf = 1'b1;
                    exp_acc = exp_acc - 256;
                end
            end
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 8'(exp_acc) || out_count !== 3'(len)
                || out_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL random_group g=%0d: valid=%b sum=%h cnt=%0d ovf=%b required 1/%h/%0d/%b",
                         g, out_valid, out_sum, out_count, out_ovf, 8'(exp_acc), len, exp_ovf);
            end
            out_ready = 1'b0;
            hold = (g % 10 == 0) ? 5 : $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'($urandom);
                step();
                checks++;
                if (out_valid !== 1'b1 || out_sum !== 8'(exp_acc) || out_count !== 3'(len)
                    || out_ovf !== exp_ovf || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL random_hold g=%0d: valid=%b sum=%h cnt=%0d ovf=%b rdy=%b", g,
                             out_valid, out_sum, out_count, out_ovf, in_ready);
                end
            end
            in_valid = 1'b0;
            pop_result();
        end
    endtask

    task automatic test_mid_reset();
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 3'd0 || out_sum !== 8'h00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: valid=%b cnt=%0d sum=%h rdy=%b required 0/0/00/0",
                     out_valid, out_count, out_sum, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_output: out_valid=%b required 0", out_valid);
            end
        end
        send_beat(8'h02, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h02 || out_count !== 3'd1 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: valid=%b sum=%h cnt=%0d ovf=%b required 1/02/1/0",
                     out_valid, out_sum, out_count, out_ovf);
        end
        pop_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_maxterms();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_stream_accumulator.md
Name: cla_stream_accumulator

Overview:
- Streaming accumulator directly downstream of the team's carry-lookahead adder.
- Consumes a valid/ready stream of NUMBITS-wide unsigned operands and feeds the running sum and each new operand into one nBitCarryLookAheadAdder instance.
- Registers the adder sum back into the accumulator and presents the group total, term count and sticky overflow on a valid/ready output port.
- Used to reduce operand groups of up to MAXTERMS beats.

Parameters:
- NUMBITS, 8: operand/sum width; must be a multiple of 4, so it matches the 4-bit adder slices.
- MAXTERMS, 16: maximum beats per group; a group is forced closed when this count is reached. Must be at least 1.
- CNTW, $clog2(MAXTERMS+1) (localparam): width of the term counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  NUMBITS  operand
- in_last  in  1  beat closes the current group
- out_valid  out  1  group result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  NUMBITS  group sum, modulo 2^NUMBITS
- out_count  out  CNTW  number of beats in the group
- out_ovf  out  1  sticky: at least one adder carry-out occurred in the group

Behaviour:
- Reset and clocking:
  - One clock, clk.
  - Reset is synchronous and active-low, on rst_n; it is sampled only on the clk rising edge.
  - While rst_n=0: state=IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=0.
  - in_ready rises in the first cycle after rst_n returns high.
  - Reset asserted mid-group or while out_valid=1 discards the group without further output.
- States: IDLE, ACCUM, DONE.
  - in_ready=1 in IDLE and ACCUM.
  - in_ready=0 in DONE.
  - out_valid=1 only in DONE.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- Datapath:
  - Adder inputs: a_in=acc, b_in=in_data, c_in=0.
  - On accept: acc <= s_out; ovf <= ovf | c_out; count <= count+1.
  - Arithmetic is unsigned and wraps modulo 2^NUMBITS.
- Transitions:
  - IDLE: accept with in_last=0 and count+1<MAXTERMS -> ACCUM. Accept with in_last=1, or with count+1==MAXTERMS (MAXTERMS=1) -> DONE.
  - ACCUM: accept with in_last=1, or with count+1==MAXTERMS -> DONE. Otherwise stay.
  - DONE: when out_ready=1 -> IDLE, with acc, count and ovf cleared to 0 on the same edge. When out_ready=0 -> hold, and all outputs stay stable.
- Outputs: out_sum=acc, out_count=count, out_ovf=ovf, driven directly from registers.
- Latency and throughput:
  - out_valid asserts the cycle after the closing beat is accepted.
  - One beat per cycle while accumulating.
  - At least one bubble (the DONE cycle) between groups.
- Boundary conditions:
  - in_valid=0 in ACCUM holds all state; groups may be arbitrarily gapped.
  - in_last on the MAXTERMS-th beat closes the group exactly once; both conditions together are not an error.
  - in_data is ignored in DONE; upstream is back-pressured.
  - out_ready with out_valid=0 has no effect.
  - When acc wraps to exactly 0, ovf=1 and out_sum=0.
  - Counter never exceeds MAXTERMS.
- Elaboration check: NUMBITS%4!=0 or MAXTERMS<1 triggers $error.

Decomposition:
- Shared package cla_pkg holds:
  - BASEADDERSIZE=4;
  - an enum typedef acc_state_t {IDLE, ACCUM, DONE};
  - a function cntw(maxterms) returning $clog2(maxterms+1).
- One sub-module instance: nBitCarryLookAheadAdder #(.NUMBITS(NUMBITS)), purely combinational, as the only adder.
- No other sub-modules; FSM, counter and registers are in this block.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, with in_valid=1 in the cycle rst_n returns high.
  - Required: out_valid=0, out_sum=0, out_count=0, out_ovf=0 throughout; in_ready=0 during reset, 1 the cycle after.
- Basic group (NUMBITS=8): send 0x10, 0x20, 0x05 (last) back-to-back.
  - Required: one cycle later out_valid=1, out_sum=0x35, out_count=3, out_ovf=0, and in_ready=0 until out_ready.
- Overflow: send 0xF0, 0x20 (last).
  - Required: out_sum=0x10, out_ovf=1, out_count=2.
  - Next group 0x01 (last) gives out_sum=0x01, out_ovf=0 (sticky flag cleared).
- MAXTERMS force-close (MAXTERMS=4): stream 5 beats of 0x01 with in_last=0.
  - Required: after beat 4, out_sum=0x04, out_count=4.
  - Beat 5 is held (in_ready=0) and starts the next group only after out_ready.
- Back-pressure and gaps: randomize in_valid gaps; hold out_ready=0 for 5 cycles.
  - Required: outputs stable while held; sums match a scoreboard model over 1000 random groups.
- Mid-group reset: accept 0x33, 0x44, then pull rst_n=0 for 1 cycle.
  - Required: no out_valid for that group; the next group 0x02 (last) gives out_sum=0x02, out_count=1.
